board_clk_gen: RTL
==================

// Module: board_clk_gen
// PURPOSE
//   Board-level clock/heartbeat generator for FPGA PULPino targets.
//   Divides the board oscillator clk into the SoC core clock div_clk_o; the divisor is runtime-programmable.
//   Releases a reset synchronised to that clock, and drives NUM_LED status LEDs in per-channel modes from one shared heartbeat counter.
// PARAMETERS
//   DIV_W        8           width of half-period divisor
//   DIV_DEFAULT  5           reset half-period in clk cycles (50 MHz -> 5 MHz)
//   NUM_LED      4           number of LED channels
//   CNT_W        26          heartbeat counter width
//   BLINK_HALF   25_000_000  heartbeat half-period in clk cycles
// PORTS
//   clk          in   1          board clock
//   rst_n        in   1          reset, asynchronous, active-low
//   div_i        in   DIV_W      new half-period value
//   div_valid_i  in   1          divisor update request
//   div_ready_o  out  1          divisor update accepted when valid&ready
//   div_clk_o    out  1          divided core clock, register output
//   div_rst_no   out  1          core reset, async assert, sync release
//   led_mode_i   in   2*NUM_LED  per-channel mode, channel n at [2n+1:2n]
//   led_o        out  NUM_LED    LED drive, registered
//   tick_o       out  1          1-cycle pulse at each heartbeat period wrap
// BEHAVIOUR
//   Reset values: div_clk_o=0, div_rst_no=0, led_o=0, tick_o=0, div_ready_o=1 (macro on).
//   Divider state:
//     - half_q resets to DIV_DEFAULT.
//     - dcnt counts 0..half_q-1.
//     - At dcnt==half_q-1: div_clk_o toggles and dcnt wraps to 0.
//     - half_q==0 is treated as 1 (clk/2). Duty is always 50%.
//   Reset release:
//     - 2-stage shift register, clocked by clk and enabled on each 0->1 toggle of div_clk_o.
//     - div_rst_no rises on the 2nd rising div_clk_o edge after rst_n deasserts.
//     - It is cleared immediately whenever rst_n is asserted, including mid-operation.
//   Heartbeat:
//     - hb_cnt counts 0..2*BLINK_HALF-1 and then wraps.
//     - tick_o is high in the cycle after hb_cnt==2*BLINK_HALF-1.
//     - phase = (hb_cnt < BLINK_HALF).
//   LED modes (registered, 1-cycle latency from led_mode_i change):
//     - 00 OFF   -> 0
//     - 01 ON    -> 1
//     - 10 BLINK -> phase
//     - 11 PULSE -> (hb_cnt < BLINK_HALF/4), i.e. 1/8 of the period
//   Width rule: CNT_W must hold 2*BLINK_HALF-1. This is checked at elaboration with $fatal.
// CONFIGURATION
//   Macro CLKDIV_RUNTIME_EN.
//   Defined:
//     - On valid&ready, div_i is captured into pend_q and div_ready_o drops.
//     - pend_q is loaded into half_q at the next 1->0 toggle of div_clk_o, and dcnt restarts at 0.
//     - No high or low phase is ever shorter than min(old, new) half-period.
//     - div_ready_o returns to 1 in the cycle after the load.
//     - A request arriving in the same cycle as a 1->0 toggle is applied at the following 1->0 toggle.
//   Not defined:
//     - div_ready_o is tied 0 and div_i/div_valid_i are ignored.
//     - half_q is the constant DIV_DEFAULT.
// STRUCTURE
//   Package board_clk_pkg:
//     - led_mode_e enum: LED_OFF, LED_ON, LED_BLINK, LED_PULSE.
//     - DIV_DEFAULT_C and BLINK_HALF_C board constants.
//   Sub-module clk_div_core:
//     - Contains half_q, pend_q, dcnt, div_clk_o, the update handshake and the div_rst_no synchroniser.
//   Top level: heartbeat counter plus the LED decode generate loop.
// TESTING
//   1. Reset, default params -> div_clk_o period 10 clk, 50% duty; div_rst_no=1 after 2nd div rising edge.
//   2. Macro on: div_i=2 while div_clk_o high -> ready=0; switch at falling toggle; then period 4 clk, no pulse <2 clk.
//   3. Macro on, div_i=0 -> div_clk_o = clk/2. Back-to-back requests -> second held until ready=1.
//   4. BLINK_HALF=8, modes {11,10,01,00} -> led[3] high 2 of 16, led[2] 8 of 16, led[1]=1, led[0]=0; tick_o every 16 clk.
//   5. rst_n pulsed mid-run -> div_rst_no, div_clk_o, led_o go 0 asynchronously; pending update discarded; half_q=DIV_DEFAULT.
//   6. Macro off: div_valid_i=1, div_i=1 -> div_ready_o=0, period stays 2*DIV_DEFAULT.

Source files
------------

// File: rtl/board_clk_pkg.sv
// Shared board constants and LED mode definitions for board_clk_gen.
//   led_mode_e    : per-channel LED mode encoding (2 bits per channel)
//   DIV_DEFAULT_C : reset half-period of the core clock in board clk cycles
//   BLINK_HALF_C  : heartbeat half-period in board clk cycles
//   led_decode()  : maps a mode plus heartbeat phase flags to an LED level
package board_clk_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PULSE = 2'b11
    } led_mode_e;

    // 50 MHz board oscillator -> 5 MHz core clock
    localparam int DIV_DEFAULT_C = 5;
    // 0.5 s half-period at 50 MHz
    localparam int BLINK_HALF_C  = 25_000_000;

    function automatic logic led_decode(input led_mode_e mode,
                                        input logic      phase,
                                        input logic      pulse);
        logic led;
        led = 1'b0;
        case (mode)
            LED_OFF:   led = 1'b0;
            LED_ON:    led = 1'b1;
            LED_BLINK: led = phase;
            LED_PULSE: led = pulse;
            default:   led = 1'b0;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Programmable 50%-duty clock divider with a reset synchroniser for the
// divided clock domain.
//   clk, rst_n   : board clock, asynchronous active-low reset
//   div_i        : requested half-period (0 behaves as 1, i.e. clk/2)
//   div_valid_i  : divisor update request
//   div_ready_o  : divisor update can be accepted
//   div_clk_o    : divided clock, straight from a flop
//   div_rst_no   : core reset, asserted with rst_n, released on the 2nd
//                  rising edge of div_clk_o
// Build option: CLKDIV_RUNTIME_EN enables runtime divisor updates; without
// it the half-period is fixed at DIV_DEFAULT and div_ready_o is tied low.
//
// Handshake: an update transfers on a clk edge where div_valid_i and
// div_ready_o are both high; div_i is captured at that edge and ready stays
// low until the captured value has been applied. The requester must hold
// div_valid_i and div_i stable until the transfer edge.
module clk_div_core
    import board_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = DIV_DEFAULT_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             div_clk_o,
    output logic             div_rst_no
);

    localparam logic [DIV_W-1:0] DIV_DEFAULT_V = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] dcnt_q;
    logic [DIV_W-1:0] last_cnt;
    logic             div_clk_q;
    logic [1:0]       sync_q;
    logic             wrap;
    logic             rise;
    logic             fall;

    // half_q == 0 wraps every cycle, giving the same result as half_q == 1
    assign last_cnt = (half_q == '0) ? '0 : half_q - DIV_W'(1);
    assign wrap     = (dcnt_q == last_cnt);
    assign rise     = wrap & ~div_clk_q;
    assign fall     = wrap &  div_clk_q;

`ifdef CLKDIV_RUNTIME_EN
    logic [DIV_W-1:0] pend_q;
    logic             ready_q;

    // A new value is only applied on a falling toggle: the high phase in
    // flight finishes with the old half-period and the low phase that starts
    // uses the new one, so no phase is shorter than min(old, new). dcnt
    // already restarts at 0 on that edge because it is a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q  <= DIV_DEFAULT_V;
            pend_q  <= DIV_DEFAULT_V;
            ready_q <= 1'b1;
        end else if (!ready_q && fall) begin
            half_q  <= pend_q;
            ready_q <= 1'b1;
        end else if (div_valid_i && ready_q) begin
            pend_q  <= div_i;
            ready_q <= 1'b0;
        end
    end

    assign div_ready_o = ready_q;
`else
    logic unused_in;

    assign half_q      = DIV_DEFAULT_V;
    assign div_ready_o = 1'b0;
    assign unused_in   = ^{div_i, div_valid_i};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            div_clk_q <= 1'b0;
            sync_q    <= 2'b00;
        end else begin
            if (wrap) begin
                dcnt_q    <= '0;
                div_clk_q <= ~div_clk_q;
            end else begin
                dcnt_q    <= dcnt_q + DIV_W'(1);
            end
            // Shift only on rising toggles so the release lines up with a
            // rising edge of the divided clock.
            if (rise) begin
                sync_q <= {sync_q[0], 1'b1};
            end
        end
    end

    assign div_clk_o  = div_clk_q;
    assign div_rst_no = sync_q[1];

endmodule

// File: rtl/board_clk_gen.sv
// Board-level clock and heartbeat generator for FPGA PULPino targets.
//   clk, rst_n   : board oscillator, asynchronous active-low reset
//   div_i        : new core-clock half-period
//   div_valid_i  : divisor update request
//   div_ready_o  : divisor update accepted when valid & ready
//   div_clk_o    : divided core clock (flop output)
//   div_rst_no   : core reset, async assert, released in div_clk_o domain
//   led_mode_i   : per-channel LED mode, channel n at [2n+1:2n]
//   led_o        : registered LED drive
//   tick_o       : one-cycle pulse after each heartbeat period wrap
// Build option: CLKDIV_RUNTIME_EN enables runtime divisor updates.
module board_clk_gen
    import board_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = DIV_DEFAULT_C,
    parameter int NUM_LED     = 4,
    parameter int CNT_W       = 26,
    parameter int BLINK_HALF  = BLINK_HALF_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_clk_o,
    output logic                 div_rst_no,
    input  logic [2*NUM_LED-1:0] led_mode_i,
    output logic [NUM_LED-1:0]   led_o,
    output logic                 tick_o
);

    localparam longint HB_LAST = 2 * longint'(BLINK_HALF) - 1;

    if (HB_LAST >= (longint'(1) << CNT_W)) begin : g_width_check
        $fatal(1, "board_clk_gen: CNT_W too narrow for 2*BLINK_HALF-1");
    end

    localparam logic [CNT_W-1:0] HB_LAST_V   = CNT_W'(HB_LAST);
    localparam logic [CNT_W-1:0] BLINK_END_V = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] PULSE_END_V = CNT_W'(BLINK_HALF / 4);

    logic [CNT_W-1:0]   hb_q;
    logic               tick_q;
    logic               phase;
    logic               pulse;
    logic [NUM_LED-1:0] led_next;
    logic [NUM_LED-1:0] led_q;

    clk_div_core #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_clk_o   (div_clk_o),
        .div_rst_no  (div_rst_no)
    );

    assign phase = (hb_q < BLINK_END_V);
    assign pulse = (hb_q < PULSE_END_V);

    for (genvar n = 0; n < NUM_LED; n++) begin : g_led
        assign led_next[n] = led_decode(led_mode_e'(led_mode_i[2*n +: 2]), phase, pulse);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q   <= '0;
            tick_q <= 1'b0;
            led_q  <= '0;
        end else begin
            tick_q <= (hb_q == HB_LAST_V);
            hb_q   <= (hb_q == HB_LAST_V) ? '0 : hb_q + CNT_W'(1);
            led_q  <= led_next;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule
